rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter with hold and timeout. It owns one shared resource and reports the owner both one-hot and as an encoded 2-bit index with a valid flag, which is the encoder's output convention.
- Sits in front of any lab datapath that four agents share, such as a bus, a display or an ALU.
- Guarantees fairness: the most recent owner has lowest priority at the next arbitration.
- Forcibly preempts an owner that holds the grant too long.

Parameters:
- HOLD_MAX, 8: maximum consecutive cycles one owner keeps the grant. Legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the hold counter.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req, input, 4: request lines. Bit i is high while requester i wants the resource.
- release, input, 1: current owner finished. Sampled only in BUSY.
- gnt, output, 4: one-hot grant. All zero when no owner.
- gnt_idx, output, 2: encoded index of the owner. Holds its last value when gnt is zero.
- busy, output, 1: high when gnt is non-zero. Equals OR of gnt.
- preempt, output, 1: one-cycle pulse when a grant ends by timeout.

Behaviour:
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - gnt=0000, gnt_idx=00, busy=0, preempt=0.
  - state=IDLE, hold_cnt=0, last=3, so requester 0 has top priority after reset.
- All outputs are registered. No combinational path from req or release to any output.
- IDLE state:
  - If req is non-zero at an edge: the winner is the first set bit scanning circularly from (last+1) mod 4 upward.
  - On that same edge: gnt=onehot(winner), gnt_idx=winner, busy=1, hold_cnt=1, state moves to BUSY.
  - Latency is one cycle from req sampled high to gnt high.
  - If req=0000, stay in IDLE with outputs unchanged.
- BUSY state, owner g. On each edge, evaluate end conditions in this priority order:
  - (a) release=1: normal end.
  - (b) req[g]=0: owner abandoned. Treated as a normal end.
  - (c) hold_cnt==HOLD_MAX: timeout. preempt=1 for exactly that next cycle.
  - (d) none of the above: hold_cnt increments and the grant is held.
- On any end:
  - gnt=0000, busy=0, last=g, hold_cnt=0, state moves to IDLE.
  - gnt_idx keeps g.
- A mandatory one-cycle gap (gnt=0) separates consecutive grants, even if requests are pending. Re-arbitration happens at the following edge.
- The gnt high pulse therefore lasts between 1 and HOLD_MAX cycles.
  - release sampled on the first BUSY edge gives a 1-cycle grant.
- release in IDLE is ignored. Changes to req bits other than the owner's are ignored during BUSY.
- A timed-out owner that keeps requesting is treated as lowest priority next time. It is regranted only if no other requester is high during the gap cycle's arbitration.
- Timeout and release at the same edge: release wins and preempt stays 0.
- preempt is 0 in every cycle except the one directly following a timeout edge.
- Reset asserted mid-grant: gnt drops asynchronously. After rst_n rises, arbitration restarts from last=3.
- Invariants:
  - gnt is always 0000 or one-hot.
  - busy == |gnt.
  - When busy=1, gnt[gnt_idx]=1.

Test Plan:
1. Reset and single request: hold rst_n=0 for 2 cycles, release it, then req=0100. At the first edge gnt=0100, gnt_idx=10, busy=1. With release=1 for one cycle, gnt=0000 at the next edge and gnt_idx stays 10.
2. Full rotation: keep req=1111, and pulse release on the 2nd BUSY cycle of each grant. Grant order must be 0,1,2,3,0. Each grant lasts 2 cycles with exactly 1 zero cycle between grants.
3. Timeout with HOLD_MAX=8: hold req=0010, release=0. gnt=0010 for exactly 8 cycles, then gnt=0000 with preempt=1 for 1 cycle. Then gnt=0010 again, since req 1 is the only requester.
4. Fairness after timeout: req=0011 constant, release=0. Owner 0 runs 8 cycles, then preempt, gap, owner 1 runs 8 cycles, then owner 0. Order is 0,1,0,1.
5. Owner drop and simultaneous events: owner 3 drops req[3] while req=0001 is pending. gnt=0000 at the next edge with preempt=0, then gnt=0001. Separately, assert release on the same edge as the timeout: preempt must stay 0.
6. Asynchronous reset mid-grant: pull rst_n low between clock edges while gnt=1000. gnt=0000 and busy=0 immediately. After rst_n rises with req=1001, the first grant goes to requester 0.

Source files
------------

// File: rtl/rr_arbiter4_if.sv
// Handshake bundle between four requesters and the round-robin arbiter.
// The master side drives requests/release; the slave side (arbiter) drives the grant.
interface rr_arbiter4_if;
  logic [3:0] req;
  logic       release_gnt;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       preempt;

  modport master (
    output req, release_gnt,
    input  gnt, gnt_idx, busy, preempt
  );

  modport slave (
    input  req, release_gnt,
    output gnt, gnt_idx, busy, preempt
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with owner release, abandonment and hold timeout.
// state | meaning
// IDLE  | no owner; arbitrate among req starting after the last owner
// BUSY  | one owner holds the grant until release, drop or timeout
module rr_arbiter4 #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter4_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [1:0]         last;
  logic [CNT_W-1:0]   hold_left;
  logic [3:0]         gnt_q;
  logic [1:0]         gnt_idx_q;
  logic               busy_q;
  logic               preempt_q;

  logic [1:0]         winner;
  logic [1:0]         cand;
  logic               found;
  logic               owner_req;
  logic               grant_end;

  // Circular scan beginning just after the previous owner; k=4 wraps back onto last.
  always_comb begin
    winner = last;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign owner_req = bus.req[gnt_idx_q];
  assign grant_end = bus.release_gnt || !owner_req || (hold_left == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 2'd3;
      hold_left <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      if (state == IDLE) begin
        if (found) begin
          gnt_q     <= 4'b0001 << winner;
          gnt_idx_q <= winner;
          busy_q    <= 1'b1;
          hold_left <= CNT_W'(HOLD_MAX - 1);
          state     <= BUSY;
        end
      end else begin
        if (grant_end) begin
          gnt_q     <= '0;
          busy_q    <= 1'b0;
          last      <= gnt_idx_q;
          hold_left <= '0;
          state     <= IDLE;
          // Only a pure timeout preempts; release and abandonment are normal ends.
          preempt_q <= !bus.release_gnt && owner_req;
        end else begin
          hold_left <= hold_left - 1'b1;
        end
      end
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.busy    = busy_q;
  assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_rr_arbiter4;
  localparam int HOLD_MAX = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(.HOLD_MAX(HOLD_MAX), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: owner index or -1, cycles held so far, last owner.
  int         m_owner;
  int         m_last;
  int         m_cnt;
  logic [1:0] m_idx;
  logic       m_pre;

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_cnt   = 0;
    m_idx   = 2'd0;
    m_pre   = 1'b0;
  endtask

  task automatic model_edge();
    int c;
    bit found;
    m_pre = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (m_owner < 0) begin
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (!found && bus.req[c]) begin
          m_owner = c;
          found   = 1;
        end
      end
      if (found) begin
        m_cnt = 1;
        m_idx = 2'(m_owner);
      end
    end else if (bus.release_gnt || !bus.req[m_owner] || m_cnt == HOLD_MAX) begin
      m_pre   = !bus.release_gnt && bus.req[m_owner];
      m_last  = m_owner;
      m_owner = -1;
      m_cnt   = 0;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] m_gnt;
    m_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    chk("gnt", bus.gnt, m_gnt);
    chk("gnt_idx", {2'b00, bus.gnt_idx}, {2'b00, m_idx});
    chk("busy", {3'b000, bus.busy}, {3'b000, (m_owner >= 0)});
    chk("preempt", {3'b000, bus.preempt}, {3'b000, m_pre});
    chk("onehot0", {3'b000, $onehot0(bus.gnt)}, 4'd1);
    chk("idx_match", {3'b000, bus.gnt[bus.gnt_idx] | ~bus.busy}, 4'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Waits for a grant, then measures how many cycles it lasts; returns at the gap cycle.
  task automatic run_grant(input string tag, output int owner, output int len);
    int n;
    n = 0;
    while (!bus.busy && n < 4) begin
      step();
      n++;
    end
    checks++;
    assert (bus.busy === 1'b1)
    else begin
      failures++;
      $error("FAIL %s_wait: observed busy=%0b expected=1", tag, bus.busy);
    end
    owner = int'(bus.gnt_idx);
    len   = 1;
    for (n = 0; n < 40; n++) begin
      step();
      if (!bus.busy) break;
      len++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "bench time limit");
  end

  initial begin
    int own;
    int len;
    logic [3:0] r;

    // Reset and single request
    rst_n = 1'b0;
    bus.req = 4'b0000;
    bus.release_gnt = 1'b0;
    model_reset();
    #1;
    check_all();
    step();
    step();
    rst_n = 1'b1;
    bus.req = 4'b0100;
    step();
    chk("t1_gnt", bus.gnt, 4'b0100);
    chk("t1_idx", {2'b00, bus.gnt_idx}, 4'd2);
    bus.release_gnt = 1'b1;
    step();
    bus.release_gnt = 1'b0;
    bus.req = 4'b0000;
    chk("t1_end_gnt", bus.gnt, 4'b0000);
    chk("t1_end_idx", {2'b00, bus.gnt_idx}, 4'd2);

    // Full rotation from a fresh reset, 2-cycle grants
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    step();
    rst_n = 1'b1;
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_grant", bus.gnt, 4'(1 << (i % 4)));
      step();
      chk("t2_hold", bus.gnt, 4'(1 << (i % 4)));
      bus.release_gnt = 1'b1;
      step();
      bus.release_gnt = 1'b0;
      chk("t2_gap", bus.gnt, 4'b0000);
    end
    bus.req = 4'b0000;

    // Timeout with a sole requester, then regrant
    bus.req = 4'b0010;
    run_grant("t3", own, len);
    chk("t3_owner", 4'(own), 4'd1);
    chk("t3_len", 4'(len), 4'(HOLD_MAX));
    chk("t3_preempt", {3'b000, bus.preempt}, 4'd1);
    step();
    chk("t3_regrant", bus.gnt, 4'b0010);
    chk("t3_pre_clear", {3'b000, bus.preempt}, 4'd0);
    bus.release_gnt = 1'b1;
    step();
    bus.release_gnt = 1'b0;

    // Fairness after timeout
    bus.req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      run_grant("t4", own, len);
      chk("t4_owner", 4'(own), 4'(i % 2));
      chk("t4_len", 4'(len), 4'(HOLD_MAX));
      chk("t4_preempt", {3'b000, bus.preempt}, 4'd1);
    end

    // Owner drop with another request pending
    bus.req = 4'b1000;
    step();
    chk("t5_own3", bus.gnt, 4'b1000);
    bus.req = 4'b0001;
    step();
    chk("t5_drop_gnt", bus.gnt, 4'b0000);
    chk("t5_drop_pre", {3'b000, bus.preempt}, 4'd0);
    step();
    chk("t5_next", bus.gnt, 4'b0001);
    // Release on the timeout edge
    for (int i = 0; i < HOLD_MAX - 1; i++) step();
    chk("t5_still", bus.gnt, 4'b0001);
    bus.release_gnt = 1'b1;
    step();
    bus.release_gnt = 1'b0;
    chk("t5_rel_gnt", bus.gnt, 4'b0000);
    chk("t5_rel_pre", {3'b000, bus.preempt}, 4'd0);

    // Asynchronous reset mid-grant
    bus.req = 4'b1000;
    step();
    chk("t6_own3", bus.gnt, 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_async_gnt", bus.gnt, 4'b0000);
    chk("t6_async_busy", {3'b000, bus.busy}, 4'd0);
    bus.req = 4'b1001;
    #2;
    rst_n = 1'b1;
    step();
    chk("t6_first", bus.gnt, 4'b0001);

    // Random traffic with sticky requests, releases and rare resets
    r = 4'b1001;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      bus.req = r;
      bus.release_gnt = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
      end else begin
        rst_n = 1'b1;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
